// File: rtl/ifetch_ctrl_if.sv
// Fetch-side bundle: redirect input, instruction-memory read port and decode handshake.
// Decode handshake: a word transfers on a rising edge where inst_valid & inst_ready; while
// inst_valid is high and inst_ready is low, inst/inst_pc/inst_exc hold stable.
interface ifetch_ctrl_if;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        im_en;
   logic [31:0] im_addr;
   logic [31:0] im_dout;
   logic [31:0] im_addrout;
   logic        im_stall;
   logic [2:0]  im_exception;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic [2:0]  inst_exc;
   logic        inst_ready;

   modport master (
      input  redirect_valid, redirect_pc,
      output im_en, im_addr,
      input  im_dout, im_addrout, im_stall, im_exception,
      output inst_valid, inst, inst_pc, inst_exc,
      input  inst_ready
   );

   modport slave (
      output redirect_valid, redirect_pc,
      input  im_en, im_addr,
      output im_dout, im_addrout, im_stall, im_exception,
      input  inst_valid, inst, inst_pc, inst_exc,
      output inst_ready
   );
endinterface

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, issues one im read per cycle under a
// credit limit, buffers returned words in a small FIFO and handles redirect / fault halt.
module ifetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   ifetch_ctrl_if.master bus,
   output logic [1:0]    dbg_state_o
);
   localparam int            CW     = $clog2(DEPTH + 1);
   localparam int            PW     = $clog2(DEPTH);
   localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic          inflight_q, inflight_d;
   logic          drop_q, drop_d;
   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [66:0]   mem_q [DEPTH];

   logic          head_valid, pop, resp, push, exc_push, issue_ok, issue;
   logic [CW:0]   credit;
   logic [31:0]   fetch_addr;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_comb begin
      head_valid = (count_q != '0);
      pop        = head_valid & bus.inst_ready;
      credit     = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
      issue_ok   = credit < {1'b0, FULL_C};
      fetch_addr = bus.redirect_valid ? bus.redirect_pc : pc_q;
      // A redirect flushes the buffer, so it always has credit unless the old read is stuck.
      issue      = ((state_q == RUN) | bus.redirect_valid)
                 & (issue_ok | bus.redirect_valid)
                 & ~(inflight_q & bus.im_stall);
      resp       = inflight_q & ~bus.im_stall;
      push       = resp & ~drop_q & ~bus.redirect_valid & (state_q == RUN);
      exc_push   = push & (bus.im_exception != 3'd0);
   end

   // FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= BOOT;
      else        state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         BOOT:    state_d = RUN;
         RUN:     if (exc_push) state_d = HALT;
         HALT:    if (bus.redirect_valid) state_d = RUN;
         default: state_d = BOOT;
      endcase
   end

   // FSM: outputs
   always_comb begin
      bus.im_en      = issue;
      bus.im_addr    = fetch_addr;
      bus.inst_valid = head_valid;
      {bus.inst, bus.inst_pc, bus.inst_exc} = head_valid ? mem_q[rd_ptr_q] : 67'd0;
   end

   assign dbg_state_o = state_q;

   always_comb begin
      pc_d = pc_q;
      if (issue)                   pc_d = fetch_addr + 32'd4;
      else if (bus.redirect_valid) pc_d = bus.redirect_pc;

      inflight_d = issue ? 1'b1 : (resp ? 1'b0 : inflight_q);

      // A redirect that cannot issue leaves a stale read in flight; discard it on return.
      drop_d = drop_q;
      if (resp) drop_d = 1'b0;
      if (bus.redirect_valid & inflight_q & bus.im_stall) drop_d = 1'b1;

      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (bus.redirect_valid) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
         unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= RESET_PC;
         inflight_q <= 1'b0;
         drop_q     <= 1'b0;
         count_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
      end else begin
         pc_q       <= pc_d;
         inflight_q <= inflight_d;
         drop_q     <= drop_d;
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
      end
   end

   // Storage needs no reset: entries are only visible while counted valid.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {bus.im_dout, bus.im_addrout, bus.im_exception};
   end

   assert property (@(posedge clk) disable iff (!rst_n) !(push && (count_q == FULL_C)));

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: cycle table for streaming/backpressure/stall/redirect, hand
// sequences for fault halt, stale-read drop and async reset, plus a delivery scoreboard.
module tb_ifetch_ctrl;
   localparam logic H = 1'b1;
   localparam logic L = 1'b0;

   typedef struct {
      logic        rdy;
      logic        stall;
      logic        rv;
      logic [31:0] rpc;
      logic        e_en;
      logic [31:0] e_addr;
      logic        e_vld;
      logic [31:0] e_pc;
      logic [2:0]  e_exc;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  dbg_state;
   logic [31:0] resp_addr = 32'h0;
   logic        exc_en = 1'b0;
   int          checks = 0;
   int          errors = 0;
   logic [34:0] exp_q[$];
   vec_t        vecs[25];

   ifetch_ctrl_if bus();

   ifetch_ctrl #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .dbg_state_o (dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   function automatic logic [31:0] code_word(input logic [31:0] addr);
      return 32'hC0DE_0000 | (addr >> 2);
   endfunction

   // instruction memory: fixed 1-cycle latency, holds its response while stalled
   always @(posedge clk) if (bus.im_en) resp_addr <= bus.im_addr;
   assign bus.im_dout      = code_word(resp_addr);
   assign bus.im_addrout   = resp_addr;
   assign bus.im_exception = (exc_en && resp_addr == 32'h20) ? 3'd2 : 3'd0;

   function automatic vec_t mk(input logic rdy, input logic stall, input logic rv,
                               input logic [31:0] rpc, input logic en, input logic [31:0] addr,
                               input logic vld, input logic [31:0] pc, input logic [2:0] exc);
      vec_t v;
      v.rdy = rdy; v.stall = stall; v.rv = rv; v.rpc = rpc;
      v.e_en = en; v.e_addr = addr; v.e_vld = vld; v.e_pc = pc; v.e_exc = exc;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // driver + scoreboard: called at a falling edge, returns at the next falling edge
   task automatic step(input vec_t v, input string tag);
      logic [34:0] e;
      bus.inst_ready     = v.rdy;
      bus.im_stall       = v.stall;
      bus.redirect_valid = v.rv;
      bus.redirect_pc    = v.rpc;
      #1;
      check({tag, " im_en"}, 32'(bus.im_en), 32'(v.e_en));
      if (v.e_en) check({tag, " im_addr"}, bus.im_addr, v.e_addr);
      check({tag, " inst_valid"}, 32'(bus.inst_valid), 32'(v.e_vld));
      if (v.e_vld) begin
         check({tag, " inst_pc"}, bus.inst_pc, v.e_pc);
         check({tag, " inst_exc"}, 32'(bus.inst_exc), 32'(v.e_exc));
      end
      if (v.e_vld && v.rdy) exp_q.push_back({v.e_exc, v.e_pc});
      if (bus.inst_valid && bus.inst_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s sb: unexpected delivery pc %h", tag, bus.inst_pc);
         end else begin
            e = exp_q.pop_front();
            check({tag, " sb pc"}, bus.inst_pc, e[31:0]);
            check({tag, " sb inst"}, bus.inst, code_word(e[31:0]));
            check({tag, " sb exc"}, 32'(bus.inst_exc), 32'(e[34:32]));
         end
      end
      @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " im_en"}, 32'(bus.im_en), 32'h0);
      check({tag, " inst_valid"}, 32'(bus.inst_valid), 32'h0);
      check({tag, " inst"}, bus.inst, 32'h0);
      check({tag, " inst_pc"}, bus.inst_pc, 32'h0);
      check({tag, " inst_exc"}, 32'(bus.inst_exc), 32'h0);
      check({tag, " state"}, 32'(dbg_state), 32'h0);
   endtask

   initial begin
      // startup / streaming
      vecs[0]  = mk(H, L, L, 32'h0,   L, 32'h0,   L, 32'h0,   3'd0);
      vecs[1]  = mk(H, L, L, 32'h0,   H, 32'h0,   L, 32'h0,   3'd0);
      vecs[2]  = mk(H, L, L, 32'h0,   H, 32'h4,   L, 32'h0,   3'd0);
      vecs[3]  = mk(H, L, L, 32'h0,   H, 32'h8,   H, 32'h0,   3'd0);
      vecs[4]  = mk(H, L, L, 32'h0,   H, 32'hC,   H, 32'h4,   3'd0);
      // decode backpressure for 5 cycles: buffer fills to 2 and fetch stops
      for (int i = 5; i < 10; i++)
         vecs[i] = mk(L, L, L, 32'h0, L, 32'h0,   H, 32'h8,   3'd0);
      vecs[10] = mk(H, L, L, 32'h0,   H, 32'h10,  H, 32'h8,   3'd0);
      vecs[11] = mk(H, L, L, 32'h0,   H, 32'h14,  H, 32'hC,   3'd0);
      vecs[12] = mk(H, L, L, 32'h0,   H, 32'h18,  H, 32'h10,  3'd0);
      vecs[13] = mk(H, L, L, 32'h0,   H, 32'h1C,  H, 32'h14,  3'd0);
      // im stall for 3 cycles with 0x1C in flight
      vecs[14] = mk(H, H, L, 32'h0,   L, 32'h0,   H, 32'h18,  3'd0);
      vecs[15] = mk(H, H, L, 32'h0,   L, 32'h0,   L, 32'h0,   3'd0);
      vecs[16] = mk(H, H, L, 32'h0,   L, 32'h0,   L, 32'h0,   3'd0);
      vecs[17] = mk(H, L, L, 32'h0,   H, 32'h20,  L, 32'h0,   3'd0);
      vecs[18] = mk(H, L, L, 32'h0,   H, 32'h24,  H, 32'h1C,  3'd0);
      vecs[19] = mk(H, L, L, 32'h0,   H, 32'h28,  H, 32'h20,  3'd0);
      // fill two words, then redirect to 0x100
      vecs[20] = mk(L, L, L, 32'h0,   L, 32'h0,   H, 32'h24,  3'd0);
      vecs[21] = mk(L, L, H, 32'h100, H, 32'h100, H, 32'h24,  3'd0);
      vecs[22] = mk(H, L, L, 32'h0,   H, 32'h104, L, 32'h0,   3'd0);
      vecs[23] = mk(H, L, L, 32'h0,   H, 32'h108, H, 32'h100, 3'd0);
      vecs[24] = mk(H, L, L, 32'h0,   H, 32'h10C, H, 32'h104, 3'd0);

      bus.inst_ready     = 1'b1;
      bus.im_stall       = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'h0;

      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;

      for (int i = 0; i < 25; i++) step(vecs[i], $sformatf("vec%0d", i));

      // fault at 0x20 halts fetch until a redirect to 0x80
      exc_en = 1'b1;
      step(mk(H, L, H, 32'h18, H, 32'h18, H, 32'h108, 3'd0), "exc0");
      step(mk(H, L, L, 32'h0,  H, 32'h1C, L, 32'h0,   3'd0), "exc1");
      step(mk(H, L, L, 32'h0,  H, 32'h20, H, 32'h18,  3'd0), "exc2");
      step(mk(H, L, L, 32'h0,  H, 32'h24, H, 32'h1C,  3'd0), "exc3");
      step(mk(H, L, L, 32'h0,  L, 32'h0,  H, 32'h20,  3'd2), "exc4");
      check("halt state", 32'(dbg_state), 32'h2);
      step(mk(H, L, L, 32'h0,  L, 32'h0,  L, 32'h0,   3'd0), "exc5");
      step(mk(H, L, L, 32'h0,  L, 32'h0,  L, 32'h0,   3'd0), "exc6");
      step(mk(H, L, H, 32'h80, H, 32'h80, L, 32'h0,   3'd0), "exc7");
      check("resume state", 32'(dbg_state), 32'h1);
      step(mk(H, L, L, 32'h0,  H, 32'h84, L, 32'h0,   3'd0), "exc8");
      step(mk(H, L, L, 32'h0,  H, 32'h88, H, 32'h80,  3'd0), "exc9");
      step(mk(H, L, L, 32'h0,  H, 32'h8C, H, 32'h84,  3'd0), "exc10");
      exc_en = 1'b0;

      // redirect while the read is stalled: the stale 0x8C return must be dropped
      step(mk(H, H, H, 32'h200, L, 32'h0,   H, 32'h88,  3'd0), "drop0");
      step(mk(H, L, L, 32'h0,   H, 32'h200, L, 32'h0,   3'd0), "drop1");
      step(mk(H, L, L, 32'h0,   H, 32'h204, L, 32'h0,   3'd0), "drop2");
      step(mk(H, L, L, 32'h0,   H, 32'h208, H, 32'h200, 3'd0), "drop3");

      // asynchronous reset between clock edges while streaming
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async reset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) step(vecs[i], $sformatf("restart%0d", i));

      check("scoreboard empty", 32'(exp_q.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
